// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Compare lanes are indexed {src_is_rt, slot_is_mem}: 0 rs/EX, 1 rs/MEM, 2 rt/EX, 3 rt/MEM.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EX      = 2'b01,
    FWD_MEM     = 2'b10
  } fwd_sel_e;

  localparam int unsigned NUM_CMP = 4;
  localparam logic [NUM_CMP-1:0] CMP_EX_MASK = 4'b0101;

endpackage

// File: rtl/pipe_hazard_ctrl_slot_cmp.sv
// Compares one ID source register against one in-flight scoreboard slot.
module hazard_slot_cmp #(
  parameter int unsigned REGNOBITS = 4
) (
  input  logic                 en,
  input  logic [REGNOBITS-1:0] src,
  input  logic                 slot_v,
  input  logic [REGNOBITS-1:0] slot_reg,
  input  logic                 slot_ld,
  output logic                 match,
  output logic                 is_ld
);

  always_comb begin
    match = en && slot_v && (slot_reg == src);
    is_ld = match && slot_ld;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: EX/MEM write scoreboard, stall/bubble/flush generation,
// rs/rt forwarding selects and stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REGNOBITS = 4,
  parameter bit          FWD_EN    = 1'b0,
  parameter int unsigned CNTBITS   = 32
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  input  logic                 id_valid,
  input  logic [REGNOBITS-1:0] id_rs,
  input  logic [REGNOBITS-1:0] id_rt,
  input  logic                 id_chk_rt,
  input  logic                 id_wr_reg,
  input  logic [REGNOBITS-1:0] id_wregno,
  input  logic                 id_is_ld,
  input  logic                 ex_mispred,
  input  logic                 cnt_clr,
  output logic                 stall_fe,
  output logic                 bubble_id,
  output logic                 flush_fe,
  output logic [1:0]           fwd_rs_sel,
  output logic [1:0]           fwd_rt_sel,
  output logic [CNTBITS-1:0]   stall_cnt,
  output logic [CNTBITS-1:0]   flush_cnt
);

  typedef struct packed {
    logic                 v;
    logic [REGNOBITS-1:0] regno;
    logic                 ld;
  } slot_t;

  slot_t              slot_ex, slot_mem;
  logic [NUM_CMP-1:0] hit, ld_hit;
  logic               hz;
  fwd_sel_e           rs_sel, rt_sel;

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
    localparam bit IS_RT  = (i / 2) == 1;
    localparam bit IS_MEM = (i % 2) == 1;
    hazard_slot_cmp #(.REGNOBITS(REGNOBITS)) u_cmp (
      .en       (IS_RT  ? id_chk_rt      : 1'b1),
      .src      (IS_RT  ? id_rt          : id_rs),
      .slot_v   (IS_MEM ? slot_mem.v     : slot_ex.v),
      .slot_reg (IS_MEM ? slot_mem.regno : slot_ex.regno),
      .slot_ld  (IS_MEM ? slot_mem.ld    : slot_ex.ld),
      .match    (hit[i]),
      .is_ld    (ld_hit[i])
    );
  end

  // With forwarding only a load still in EX cannot be bypassed; EX wins over MEM
  // because it holds the youngest writer of the register.
  always_comb begin
    hz     = 1'b0;
    rs_sel = FWD_REGFILE;
    rt_sel = FWD_REGFILE;
    if (FWD_EN) begin
      hz = id_valid && |(ld_hit & CMP_EX_MASK);
      if (id_valid) begin
        if (hit[0])      rs_sel = FWD_EX;
        else if (hit[1]) rs_sel = FWD_MEM;
        if (hit[2])      rt_sel = FWD_EX;
        else if (hit[3]) rt_sel = FWD_MEM;
      end
    end else begin
      hz = id_valid && |hit;
    end
  end

  always_comb begin
    flush_fe   = RESET_N && ex_mispred;
    stall_fe   = RESET_N && hz && !ex_mispred;
    bubble_id  = stall_fe || flush_fe;
    fwd_rs_sel = RESET_N ? 2'(rs_sel) : 2'b00;
    fwd_rt_sel = RESET_N ? 2'(rt_sel) : 2'b00;
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_ex  <= '0;
      slot_mem <= '0;
    end else begin
      slot_mem <= slot_ex;
      if (bubble_id) slot_ex <= '0;
      else           slot_ex <= '{v: id_valid && id_wr_reg, regno: id_wregno, ld: id_is_ld};
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNTBITS'(stall_fe);
      flush_cnt <= flush_cnt + CNTBITS'(flush_fe);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a stall-only and a forwarding instance share one stimulus
// stream; a behavioural scoreboard model predicts both, plus directed pipeline scenarios.
module tb_pipe_hazard_ctrl;

  localparam int unsigned C0 = 32;
  localparam int unsigned C1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_valid, id_chk_rt, id_wr_reg, id_is_ld, ex_mispred, cnt_clr;
  logic [3:0] id_rs, id_rt, id_wregno;

  logic          stall0, bubble0, flush0, stall1, bubble1, flush1;
  logic [1:0]    rs0, rt0, rs1, rt1;
  logic [C0-1:0] scnt0, fcnt0;
  logic [C1-1:0] scnt1, fcnt1;

  pipe_hazard_ctrl #(.REGNOBITS(4), .FWD_EN(1'b0), .CNTBITS(C0)) u_dut0 (
    .clk(clk), .RESET_N(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_chk_rt(id_chk_rt), .id_wr_reg(id_wr_reg), .id_wregno(id_wregno), .id_is_ld(id_is_ld),
    .ex_mispred(ex_mispred), .cnt_clr(cnt_clr), .stall_fe(stall0), .bubble_id(bubble0),
    .flush_fe(flush0), .fwd_rs_sel(rs0), .fwd_rt_sel(rt0), .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  pipe_hazard_ctrl #(.REGNOBITS(4), .FWD_EN(1'b1), .CNTBITS(C1)) u_dut1 (
    .clk(clk), .RESET_N(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_chk_rt(id_chk_rt), .id_wr_reg(id_wr_reg), .id_wregno(id_wregno), .id_is_ld(id_is_ld),
    .ex_mispred(ex_mispred), .cnt_clr(cnt_clr), .stall_fe(stall1), .bubble_id(bubble1),
    .flush_fe(flush1), .fwd_rs_sel(rs1), .fwd_rt_sel(rt1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  typedef struct {
    int unsigned d;
    logic        stall, bubble, flush;
    logic [1:0]  rs, rt;
    logic [31:0] scnt, fcnt;
  } exp_t;

  typedef struct {
    bit       v;
    bit [3:0] r;
    bit       ld;
  } mslot_t;

  exp_t        q[$];
  exp_t        last[2];
  mslot_t      m_ex[2], m_mem[2];
  logic [31:0] m_scnt[2], m_fcnt[2];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] cmask(input int unsigned d);
    return (d == 0) ? 32'hffff_ffff : 32'h0000_000f;
  endfunction

  function automatic void model_clear();
    for (int unsigned d = 0; d < 2; d++) begin
      m_ex[d]   = '{0, 0, 0};
      m_mem[d]  = '{0, 0, 0};
      m_scnt[d] = '0;
      m_fcnt[d] = '0;
    end
  endfunction

  function automatic exp_t predict(input int unsigned d);
    exp_t e;
    bit xs, ms, xt, mt, hz;
    e.d = d; e.stall = 0; e.bubble = 0; e.flush = 0; e.rs = 2'b00; e.rt = 2'b00;
    e.scnt = m_scnt[d]; e.fcnt = m_fcnt[d];
    if (rst_n !== 1'b1) return e;
    xs = m_ex[d].v  && (m_ex[d].r  == id_rs);
    ms = m_mem[d].v && (m_mem[d].r == id_rs);
    xt = id_chk_rt && m_ex[d].v  && (m_ex[d].r  == id_rt);
    mt = id_chk_rt && m_mem[d].v && (m_mem[d].r == id_rt);
    if (d == 0) hz = id_valid && (xs || ms || xt || mt);
    else        hz = id_valid && m_ex[d].ld && (xs || xt);
    e.flush  = ex_mispred;
    e.stall  = hz && !ex_mispred;
    e.bubble = e.stall || ex_mispred;
    if (d == 1 && id_valid) begin
      e.rs = xs ? 2'b01 : (ms ? 2'b10 : 2'b00);
      e.rt = xt ? 2'b01 : (mt ? 2'b10 : 2'b00);
    end
    return e;
  endfunction

  task automatic model_tick();
    if (rst_n !== 1'b1) begin
      model_clear();
      return;
    end
    for (int unsigned d = 0; d < 2; d++) begin
      m_mem[d] = m_ex[d];
      if (last[d].bubble) m_ex[d] = '{0, 0, 0};
      else                m_ex[d] = '{id_valid && id_wr_reg, id_wregno, id_is_ld};
      if (cnt_clr) begin
        m_scnt[d] = '0;
        m_fcnt[d] = '0;
      end else begin
        m_scnt[d] = (m_scnt[d] + 32'(last[d].stall)) & cmask(d);
        m_fcnt[d] = (m_fcnt[d] + 32'(last[d].flush)) & cmask(d);
      end
    end
  endtask

  task automatic sample();
    if (rst_n !== 1'b1) model_clear();
    for (int unsigned d = 0; d < 2; d++) begin
      last[d] = predict(d);
      q.push_back(last[d]);
    end
  endtask

  task automatic compare();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.d == 0) begin
        chk("d0_stall", 32'(stall0), 32'(e.stall));
        chk("d0_bubble", 32'(bubble0), 32'(e.bubble));
        chk("d0_flush", 32'(flush0), 32'(e.flush));
        chk("d0_fwd_rs", 32'(rs0), 32'(e.rs));
        chk("d0_fwd_rt", 32'(rt0), 32'(e.rt));
        chk("d0_stall_cnt", 32'(scnt0), e.scnt);
        chk("d0_flush_cnt", 32'(fcnt0), e.fcnt);
      end else begin
        chk("d1_stall", 32'(stall1), 32'(e.stall));
        chk("d1_bubble", 32'(bubble1), 32'(e.bubble));
        chk("d1_flush", 32'(flush1), 32'(e.flush));
        chk("d1_fwd_rs", 32'(rs1), 32'(e.rs));
        chk("d1_fwd_rt", 32'(rt1), 32'(e.rt));
        chk("d1_stall_cnt", 32'(scnt1), e.scnt);
        chk("d1_flush_cnt", 32'(fcnt1), e.fcnt);
      end
    end
  endtask

  // One pipeline cycle: inputs change just after the edge, outputs checked on negedge.
  task automatic issue(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic chk_rt, input logic wr, input logic [3:0] wreg,
                       input logic ld, input logic mis, input logic clr);
    @(posedge clk);
    model_tick();
    #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_chk_rt = chk_rt; id_wr_reg = wr;
    id_wregno = wreg; id_is_ld = ld; ex_mispred = mis; cnt_clr = clr;
    sample();
    @(negedge clk);
    compare();
  endtask

  // Entered on a negedge; the assertion lands mid-cycle to exercise the async path.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sample();
    compare();
    id_valid = 0; id_rs = 0; id_rt = 0; id_chk_rt = 0; id_wr_reg = 0;
    id_wregno = 0; id_is_ld = 0; ex_mispred = 0; cnt_clr = 0;
    @(posedge clk);
    model_tick();
    #1;
    sample();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    sample();
    compare();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_chk_rt = 0; id_wr_reg = 0;
    id_wregno = 0; id_is_ld = 0; ex_mispred = 0; cnt_clr = 0;
    model_clear();
    last[0] = predict(0);
    last[1] = predict(1);
    @(negedge clk);
    do_reset();

    // Back-to-back ALU dependency: two stall cycles without forwarding
    issue(1, 4'd1, 4'd2, 1, 1, 4'd3, 0, 0, 0);
    issue(1, 4'd3, 4'd5, 1, 1, 4'd4, 0, 0, 0);
    chk("t1_stall_a", 32'(stall0), 32'd1);
    chk("t1_bubble_a", 32'(bubble0), 32'd1);
    chk("t1_fwd_ex", 32'(rs1), 32'd1);
    issue(1, 4'd3, 4'd5, 1, 1, 4'd4, 0, 0, 0);
    chk("t1_stall_b", 32'(stall0), 32'd1);
    issue(1, 4'd3, 4'd5, 1, 1, 4'd4, 0, 0, 0);
    chk("t1_stall_c", 32'(stall0), 32'd0);
    chk("t1_stall_cnt", 32'(scnt0), 32'd2);

    // Load-use with forwarding, then ALU-to-ALU forwarding
    do_reset();
    issue(1, 4'd1, 4'd0, 0, 1, 4'd3, 1, 0, 0);
    issue(1, 4'd3, 4'd0, 0, 1, 4'd4, 0, 0, 0);
    chk("t2_ld_stall", 32'(stall1), 32'd1);
    issue(1, 4'd3, 4'd0, 0, 1, 4'd4, 0, 0, 0);
    chk("t2_ld_nostall", 32'(stall1), 32'd0);
    chk("t2_fwd_mem", 32'(rs1), 32'd2);
    chk("t2_stall_cnt", 32'(scnt1), 32'd1);
    issue(1, 4'd1, 4'd0, 0, 1, 4'd5, 0, 0, 0);
    issue(1, 4'd5, 4'd0, 0, 1, 4'd6, 0, 0, 0);
    chk("t2_alu_nostall", 32'(stall1), 32'd0);
    chk("t2_fwd_ex", 32'(rs1), 32'd1);

    // Hazard coinciding with a mispredict
    do_reset();
    issue(1, 4'd1, 4'd2, 1, 1, 4'd3, 0, 0, 0);
    issue(1, 4'd3, 4'd5, 1, 1, 4'd4, 0, 1, 0);
    chk("t3_stall", 32'(stall0), 32'd0);
    chk("t3_flush", 32'(flush0), 32'd1);
    chk("t3_bubble", 32'(bubble0), 32'd1);
    issue(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0);
    chk("t3_flush_cnt", 32'(fcnt0), 32'd1);
    chk("t3_stall_cnt", 32'(scnt0), 32'd0);

    // JAL r15 mispredicts; its target reads r15 from the MEM slot
    do_reset();
    issue(1, 4'd0, 4'd0, 0, 1, 4'd15, 0, 0, 0);
    issue(1, 4'd2, 4'd2, 1, 1, 4'd7, 0, 1, 0);
    issue(1, 4'd15, 4'd0, 0, 1, 4'd8, 0, 0, 0);
    chk("t4_stall", 32'(stall0), 32'd1);
    chk("t4_fwd_mem", 32'(rs1), 32'd2);
    chk("t4_fwd_nostall", 32'(stall1), 32'd0);

    // rt only counts when the instruction reads it
    do_reset();
    issue(1, 4'd1, 4'd2, 1, 1, 4'd3, 0, 0, 0);
    issue(1, 4'd7, 4'd3, 0, 1, 4'd6, 0, 0, 0);
    chk("t5_addi", 32'(stall0), 32'd0);
    do_reset();
    issue(1, 4'd1, 4'd2, 1, 1, 4'd3, 0, 0, 0);
    issue(1, 4'd7, 4'd3, 1, 0, 4'd0, 0, 0, 0);
    chk("t5_sw", 32'(stall0), 32'd1);
    chk("t5_sw_fwd", 32'(rt1), 32'd1);

    // Reset mid-stall, then counter clear during a stall cycle
    do_reset();
    issue(1, 4'd1, 4'd2, 1, 1, 4'd3, 0, 0, 0);
    issue(1, 4'd3, 4'd5, 1, 1, 4'd4, 0, 0, 0);
    chk("t6_pre_stall", 32'(stall0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_stall", 32'(stall0), 32'd0);
    chk("t6_rst_bubble", 32'(bubble0), 32'd0);
    @(negedge clk);
    do_reset();
    issue(1, 4'd3, 4'd5, 1, 1, 4'd4, 0, 0, 0);
    chk("t6_post_rst", 32'(stall0), 32'd0);
    issue(1, 4'd1, 4'd2, 1, 1, 4'd3, 0, 0, 0);
    issue(1, 4'd3, 4'd5, 1, 1, 4'd9, 0, 0, 1);
    issue(1, 4'd3, 4'd5, 1, 1, 4'd9, 0, 0, 0);
    chk("t6_clr", 32'(scnt0), 32'd0);
    issue(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0);
    chk("t6_after_clr", 32'(scnt0), 32'd1);

    // Random traffic over a small register window to provoke frequent matches
    for (int unsigned i = 0; i < 400; i++) begin
      issue(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
